decoder_scan_nbit: RTL and testbench
====================================

Name: decoder_scan_nbit

Overview:
Parametrised, registered N-to-2**N decoder. Successor to the combinational one-hot decoder.
- Adds a thermometer output code.
- Adds an auto-scan mode that steps through all outputs by itself, with a programmable dwell time and break-before-make dead time.
- Target use: LED-matrix row/column drivers, mux select sequencing and enable fan-out.
- Sits between control logic and output drivers.

Parameters:
- N, 3, select width; output width is 2**N.
- DWELL_W, 8, width of the dwell-count input.
- DEAD, 1, number of all-zero cycles between scan steps; 0 means no dead time.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  0 forces the output to zero and the FSM to IDLE.
- mode  input  2  bit1: 0 = direct (decode a), 1 = auto-scan. bit0: 0 = one-hot code, 1 = thermometer code.
- a  input  N  select input used in direct mode.
- dwell  input  DWELL_W  cycles per scan step; 0 is treated as 1.
- y  output  2**N  registered decoded output.
- idx  output  N  registered index currently being driven.
- step_pulse  output  1  one-cycle pulse when a new scan index is driven.
- wrap_pulse  output  1  one-cycle pulse when the scan index returns to 0.

Behaviour:
- Reset (sync, active-high): y=0, idx=0, step_pulse=0, wrap_pulse=0, state=IDLE, dwell counter=0. Reset overrides every other input.
- All outputs are registered. Every input change is reflected at the earliest one cycle later.
- Output code, with k=idx:
  - one-hot: y = 1<<k.
  - thermometer: y bits [k:0] = 1, all others 0.
  - mode[0] is sampled every cycle, so the code type may change at any time, latency 1.
- FSM states: IDLE, DIRECT, SCAN_ON, SCAN_DEAD.
- IDLE:
  - y=0.
  - enable=1 and mode[1]=0 -> DIRECT.
  - enable=1 and mode[1]=1 -> SCAN_ON with idx=0, counter=max(dwell,1), step_pulse=1.
- DIRECT:
  - Each cycle: idx<=a, y<=code(a). Latency 1 from a to y.
  - step_pulse and wrap_pulse stay 0.
  - mode[1]=1 -> SCAN_ON, restarting at idx=0 with step_pulse=1.
- SCAN_ON:
  - y=code(idx). Counter decrements each cycle.
  - On the last cycle (counter==1): go to SCAN_DEAD if DEAD>0, otherwise advance directly.
  - Dwell per step = max(dwell,1) cycles.
- SCAN_DEAD:
  - y=0 for exactly DEAD cycles, idx held.
  - Then -> SCAN_ON with idx advanced.
- Advance:
  - idx <= idx+1 mod 2**N, counter reloaded from the current dwell.
  - step_pulse=1 in the first cycle the new idx is visible on y.
  - wrap_pulse=1 in that same cycle when the new idx==0 (after 2**N-1).
- Step period = max(dwell,1)+DEAD cycles; full sweep = 2**N times that.
- Any state with enable=0 -> IDLE next cycle; y=0, pulses 0; idx holds its last value.
- SCAN_ON or SCAN_DEAD with mode[1]=0 -> DIRECT next cycle; y=code(a).
- A dwell change mid-step has no effect until the next reload.
- The FSM never stalls. Unreachable state encodings recover to IDLE.
- Widths: counter is DWELL_W bits. Index arithmetic wraps modulo 2**N, with no overflow flag.

Optional Feature:
Macro DECODER_SCAN_PINGPONG_EN.
- Defined:
  - Scan direction bounces: 0,1,…,2**N-1,2**N-2,…,1,0,1,…
  - The endpoint is not repeated.
  - wrap_pulse fires on arrival at 2**N-1 and on arrival at 0.
  - Direction resets to "up" whenever scan is (re)entered or reset is asserted.
- Not defined:
  - Upward wrap only, as described in Behaviour.
  - No direction register is synthesised.

Test Plan:
(Defaults N=3, DEAD=1 unless stated.)
- Reset held 3 cycles with enable=1, mode=2'b10 -> y=0, idx=0, no pulses; first cycle after release -> y=8'b00000001, step_pulse=1.
- Direct one-hot, enable=1, mode=2'b00, a stepped 0..7 one per cycle -> y follows 1<<a one cycle later. enable=0 -> y=8'h00 next cycle.
- Thermometer direct, mode=2'b01, a=5 -> y=8'b00111111 one cycle later. mode[0] toggled to 0 -> y=8'b00100000 next cycle.
- Scan, mode=2'b10, dwell=2 -> y sequence 01,01,00,02,02,00,04,… Step period 3 cycles; step_pulse on each new value; wrap_pulse once every 24 cycles, when y returns to 01. dwell=0 -> period 2.
- Mid-operation events during scan at idx=4:
  - enable=0 -> y=0 next cycle.
  - Re-enable -> restarts at idx=0.
  - mode -> 2'b00 with a=6 -> y=8'b01000000 next cycle.
  - Synchronous reset during SCAN_DEAD -> all outputs 0 next cycle.
- With DECODER_SCAN_PINGPONG_EN, dwell=1, DEAD=0 -> idx sequence 0..7,6..0,1; wrap_pulse at idx=7 and idx=0; 14-cycle period.

Source files
------------

// File: rtl/decoder_scan_nbit_if.sv
// Control/output bundle for decoder_scan_nbit: the controller drives the master
// side, and the decoder presents the slave side.
interface decoder_scan_nbit_if #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
);
  logic               enable;
  logic [1:0]         mode;
  logic [N-1:0]       a;
  logic [DWELL_W-1:0] dwell;
  logic [2**N-1:0]    y;
  logic [N-1:0]       idx;
  logic               step_pulse;
  logic               wrap_pulse;

  modport master (
    output enable, mode, a, dwell,
    input  y, idx, step_pulse, wrap_pulse
  );

  modport slave (
    input  enable, mode, a, dwell,
    output y, idx, step_pulse, wrap_pulse
  );
endinterface

// File: rtl/decoder_scan_nbit.sv
// Registered N-to-2**N decoder with one-hot/thermometer codes and an auto-scan sequencer.
// Define DECODER_SCAN_PINGPONG_EN to make the scan bounce between the end indices instead of wrapping.
module decoder_scan_nbit #(
  parameter int N       = 3,
  parameter int DWELL_W = 8,
  parameter int DEAD    = 1
) (
  input logic               clk,
  input logic               reset,
  decoder_scan_nbit_if.slave bus
);
  localparam int W      = 2**N;
  localparam int DEAD_W = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  localparam logic [N-1:0] IDX_MAX = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIRECT    = 2'd1,
    SCAN_ON   = 2'd2,
    SCAN_DEAD = 2'd3
  } state_e;

  state_e             state_q;
  logic [N-1:0]       idx_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DEAD_W-1:0]  dead_q;
  logic [W-1:0]       y_q;
  logic               step_q;
  logic               wrap_q;

  logic [DWELL_W-1:0] dwell_ld_d;
  logic [N-1:0]       adv_idx_d;
  logic               adv_wrap_d;
  logic               entry_s;
  logic               adv_s;

  function automatic logic [W-1:0] code_f(input logic [N-1:0] k, input logic thermo);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      v[i] = thermo ? (N'(i) <= k) : (N'(i) == k);
    end
    return v;
  endfunction

  assign dwell_ld_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

`ifdef DECODER_SCAN_PINGPONG_EN
  logic dir_q;
  logic adv_dir_d;

  // dir_q=1 means counting up; the endpoint turns around without repeating itself.
  always_comb begin
    adv_idx_d = idx_q;
    adv_dir_d = dir_q;
    if (dir_q) begin
      if (idx_q == IDX_MAX) begin
        adv_idx_d = idx_q - N'(1);
        adv_dir_d = 1'b0;
      end else begin
        adv_idx_d = idx_q + N'(1);
      end
    end else begin
      if (idx_q == '0) begin
        adv_idx_d = idx_q + N'(1);
        adv_dir_d = 1'b1;
      end else begin
        adv_idx_d = idx_q - N'(1);
      end
    end
    adv_wrap_d = (adv_idx_d == IDX_MAX) || (adv_idx_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= 1'b1;
    end else if (entry_s) begin
      dir_q <= 1'b1;
    end else if (adv_s) begin
      dir_q <= adv_dir_d;
    end else begin
      dir_q <= dir_q;
    end
  end
`else
  always_comb begin
    adv_idx_d  = idx_q + N'(1);
    adv_wrap_d = (adv_idx_d == '0);
  end
`endif

  // Scan (re)entry and index advance are shared by several states, so decode them once.
  always_comb begin
    entry_s = 1'b0;
    adv_s   = 1'b0;
    if (bus.enable && bus.mode[1]) begin
      case (state_q)
        IDLE, DIRECT: entry_s = 1'b1;
        SCAN_ON:      adv_s   = (cnt_q <= DWELL_W'(1)) && (DEAD == 0);
        SCAN_DEAD:    adv_s   = (dead_q <= DEAD_W'(1));
        default:      adv_s   = 1'b0;
      endcase
    end else begin
      entry_s = 1'b0;
      adv_s   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dead_q  <= '0;
      y_q     <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (!bus.enable) begin
      state_q <= IDLE;
      y_q     <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (entry_s) begin
      state_q <= SCAN_ON;
      idx_q   <= '0;
      cnt_q   <= dwell_ld_d;
      y_q     <= code_f('0, bus.mode[0]);
      step_q  <= 1'b1;
      wrap_q  <= 1'b0;
    end else if (adv_s) begin
      state_q <= SCAN_ON;
      idx_q   <= adv_idx_d;
      cnt_q   <= dwell_ld_d;
      y_q     <= code_f(adv_idx_d, bus.mode[0]);
      step_q  <= 1'b1;
      wrap_q  <= adv_wrap_d;
    end else if (!bus.mode[1]) begin
      state_q <= DIRECT;
      idx_q   <= bus.a;
      y_q     <= code_f(bus.a, bus.mode[0]);
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        SCAN_ON: begin
          // Reaching the last dwell cycle here implies DEAD>0; the DEAD==0 case advanced above.
          if (cnt_q > DWELL_W'(1)) begin
            cnt_q <= cnt_q - DWELL_W'(1);
            y_q   <= code_f(idx_q, bus.mode[0]);
          end else begin
            state_q <= SCAN_DEAD;
            dead_q  <= DEAD_W'(DEAD);
            y_q     <= '0;
          end
        end
        SCAN_DEAD: begin
          dead_q <= dead_q - DEAD_W'(1);
          y_q    <= '0;
        end
        default: begin
          state_q <= IDLE;
          y_q     <= '0;
        end
      endcase
    end
  end

  assign bus.y          = y_q;
  assign bus.idx        = idx_q;
  assign bus.step_pulse = step_q;
  assign bus.wrap_pulse = wrap_q;
endmodule

// File: tb/tb_decoder_scan_nbit.sv
// Directed bench for decoder_scan_nbit: DEAD=1 instance for most scenarios, DEAD=0 instance for back-to-back steps.
module tb_decoder_scan_nbit;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  decoder_scan_nbit_if #(.N(3), .DWELL_W(8)) bus1 ();
  decoder_scan_nbit_if #(.N(3), .DWELL_W(8)) bus2 ();

  decoder_scan_nbit #(.N(3), .DWELL_W(8), .DEAD(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  decoder_scan_nbit #(.N(3), .DWELL_W(8), .DEAD(0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Index reached after s scan steps.
  function automatic int exp_idx(int s);
    int p;
`ifdef DECODER_SCAN_PINGPONG_EN
    p = s % 14;
    if (p > 7) p = 14 - p;
`else
    p = s % 8;
`endif
    return p;
  endfunction

  function automatic logic exp_wrap(int s);
    int k;
    k = exp_idx(s);
`ifdef DECODER_SCAN_PINGPONG_EN
    return (s > 0) && (k == 0 || k == 7);
`else
    return (s > 0) && (k == 0);
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus1.y !== 8'h00 || bus1.idx !== 3'd0 || bus1.step_pulse !== 1'b0 || bus1.wrap_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: y=%h idx=%0d step=%b wrap=%b, want 00/0/0/0", bus1.y, bus1.idx, bus1.step_pulse, bus1.wrap_pulse);
      end
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (bus1.y !== 8'h01 || bus1.idx !== 3'd0 || bus1.step_pulse !== 1'b1 || bus1.wrap_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: y=%h idx=%0d step=%b wrap=%b, want 01/0/1/0", bus1.y, bus1.idx, bus1.step_pulse, bus1.wrap_pulse);
    end
  endtask

  task automatic test_scan();
    int dw_list [2] = '{2, 0};
    for (int t = 0; t < 2; t++) begin
      int dw_eff;
      int per;
      int ncyc;
      dw_eff = (dw_list[t] == 0) ? 1 : dw_list[t];
      per    = dw_eff + 1;
      ncyc   = 16 * per + 2;
      bus1.enable = 1'b0;
      tick();
      bus1.enable = 1'b1;
      bus1.mode   = 2'b10;
      bus1.dwell  = 8'(dw_list[t]);
      for (int c = 0; c < ncyc; c++) begin
        int p;
        int s;
        logic [7:0] y_exp;
        tick();
        p = c % per;
        s = c / per;
        y_exp = (p < dw_eff) ? (8'b1 << exp_idx(s)) : 8'h00;
        n_tests++;
        if (bus1.y !== y_exp || bus1.idx !== 3'(exp_idx(s))) begin
          n_fail++;
          $display("FAIL scan_y dwell=%0d c=%0d: y=%h idx=%0d, want %h/%0d", dw_list[t], c, bus1.y, bus1.idx, y_exp, exp_idx(s));
        end
        n_tests++;
        if (bus1.step_pulse !== (p == 0) || bus1.wrap_pulse !== ((p == 0) && exp_wrap(s))) begin
          n_fail++;
          $display("FAIL scan_pulse dwell=%0d c=%0d: step=%b wrap=%b, want %b/%b", dw_list[t], c,
                   bus1.step_pulse, bus1.wrap_pulse, (p == 0), ((p == 0) && exp_wrap(s)));
        end
      end
    end
  endtask

  task automatic test_direct();
    bus1.enable = 1'b0;
    tick();
    bus1.enable = 1'b1;
    bus1.mode   = 2'b00;
    for (int i = 0; i < 8; i++) begin
      bus1.a = 3'(i);
      tick();
      n_tests++;
      if (bus1.y !== (8'b1 << i) || bus1.idx !== 3'(i) || bus1.step_pulse !== 1'b0 || bus1.wrap_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL direct_a%0d: y=%h idx=%0d step=%b, want %h/%0d/0", i, bus1.y, bus1.idx, bus1.step_pulse, 8'b1 << i, i);
      end
    end
    bus1.enable = 1'b0;
    tick();
    n_tests++;
    if (bus1.y !== 8'h00 || bus1.idx !== 3'd7) begin
      n_fail++;
      $display("FAIL direct_disable: y=%h idx=%0d, want 00/7", bus1.y, bus1.idx);
    end
  endtask

  task automatic test_thermo();
    logic [1:0] md [4] = '{2'b01, 2'b00, 2'b01, 2'b01};
    logic [2:0] av [4] = '{3'd5, 3'd5, 3'd7, 3'd0};
    logic [7:0] ye [4] = '{8'h3F, 8'h20, 8'hFF, 8'h01};
    bus1.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.mode = md[i];
      bus1.a    = av[i];
      tick();
      n_tests++;
      if (bus1.y !== ye[i]) begin
        n_fail++;
        $display("FAIL thermo_%0d: y=%h, want %h", i, bus1.y, ye[i]);
      end
    end
  endtask

  task automatic test_mid_scan();
    bus1.enable = 1'b0;
    tick();
    bus1.enable = 1'b1;
    bus1.mode   = 2'b10;
    bus1.dwell  = 8'd2;
    repeat (13) tick();
    n_tests++;
    if (bus1.idx !== 3'd4 || bus1.y !== 8'h10 || bus1.step_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reach4: idx=%0d y=%h step=%b, want 4/10/1", bus1.idx, bus1.y, bus1.step_pulse);
    end
    bus1.enable = 1'b0;
    tick();
    n_tests++;
    if (bus1.y !== 8'h00 || bus1.idx !== 3'd4 || bus1.step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_disable: y=%h idx=%0d step=%b, want 00/4/0", bus1.y, bus1.idx, bus1.step_pulse);
    end
    bus1.enable = 1'b1;
    tick();
    n_tests++;
    if (bus1.y !== 8'h01 || bus1.idx !== 3'd0 || bus1.step_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reenable: y=%h idx=%0d step=%b, want 01/0/1", bus1.y, bus1.idx, bus1.step_pulse);
    end
    repeat (12) tick();
    bus1.mode = 2'b00;
    bus1.a    = 3'd6;
    tick();
    n_tests++;
    if (bus1.y !== 8'h40 || bus1.idx !== 3'd6 || bus1.step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_to_direct: y=%h idx=%0d step=%b, want 40/6/0", bus1.y, bus1.idx, bus1.step_pulse);
    end
    bus1.mode = 2'b10;
    tick();
    n_tests++;
    if (bus1.y !== 8'h01 || bus1.idx !== 3'd0 || bus1.step_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_direct_to_scan: y=%h idx=%0d step=%b, want 01/0/1", bus1.y, bus1.idx, bus1.step_pulse);
    end
    tick();
    tick();
    n_tests++;
    if (bus1.y !== 8'h00 || bus1.step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_dead: y=%h step=%b, want 00/0", bus1.y, bus1.step_pulse);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (bus1.y !== 8'h00 || bus1.idx !== 3'd0 || bus1.step_pulse !== 1'b0 || bus1.wrap_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_dead: y=%h idx=%0d step=%b wrap=%b, want 00/0/0/0", bus1.y, bus1.idx, bus1.step_pulse, bus1.wrap_pulse);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (bus1.y !== 8'h01 || bus1.step_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after_reset: y=%h step=%b, want 01/1", bus1.y, bus1.step_pulse);
    end
  endtask

  task automatic test_back_to_back();
    bus2.enable = 1'b1;
    bus2.mode   = 2'b10;
    bus2.dwell  = 8'd1;
    for (int c = 0; c < 30; c++) begin
      tick();
      n_tests++;
      if (bus2.idx !== 3'(exp_idx(c)) || bus2.y !== (8'b1 << exp_idx(c)) ||
          bus2.step_pulse !== 1'b1 || bus2.wrap_pulse !== exp_wrap(c)) begin
        n_fail++;
        $display("FAIL b2b c=%0d: idx=%0d y=%h step=%b wrap=%b, want %0d/%h/1/%b", c, bus2.idx, bus2.y,
                 bus2.step_pulse, bus2.wrap_pulse, exp_idx(c), 8'b1 << exp_idx(c), exp_wrap(c));
      end
    end
    bus2.enable = 1'b0;
    tick();
    n_tests++;
    if (bus2.y !== 8'h00 || bus2.step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_disable: y=%h step=%b, want 00/0", bus2.y, bus2.step_pulse);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus1.enable = 1'b1;
    bus1.mode   = 2'b10;
    bus1.a      = 3'd0;
    bus1.dwell  = 8'd2;
    bus2.enable = 1'b0;
    bus2.mode   = 2'b00;
    bus2.a      = 3'd0;
    bus2.dwell  = 8'd1;
    test_reset();
    test_scan();
    test_direct();
    test_thermo();
    test_mid_scan();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
